copy_token_reader: RTL and testbench
====================================

// Module: copy_token_reader
// PURPOSE
//   Read side of the parser->copy token FIFO. Pops 33-bit copy tokens from the FIFO.
//   Splits each token into overlap-safe chunks and issues them to the copy engine.
//   Handshake to the engine is valid/ready.
//   Sits between the parser-copy FIFO (1-cycle registered read latency) and the
//   history-buffer copy engine.
// PARAMETERS
//   WIDTH  33  token width; fixed format {last[32], offset[31:16], length[15:0]}
//   CHUNK  16  max bytes per issued chunk; power of two, 1..64
// PORTS
//   clk         in   1   clock
//   srst        in   1   synchronous reset, active-high
//   fifo_empty  in   1   FIFO empty flag
//   fifo_dout   in   33  FIFO read data; valid the cycle after fifo_rd_en
//   fifo_rd_en  out  1   FIFO pop request
//   cp_valid    out  1   chunk command valid
//   cp_ready    in   1   copy engine accepts chunk
//   cp_offset   out  16  back-reference distance in bytes (>=1)
//   cp_len      out  16  chunk length in bytes (1..CHUNK)
//   cp_last     out  1   final chunk of a token whose last bit was set
//   busy        out  1   token in flight (state != IDLE)
//   err         out  1   sticky: illegal token seen; cleared only by srst
//   byte_cnt    out  32  only when COPY_READER_STATS_EN is defined
// BEHAVIOUR
//   Reset values (srst, one cycle): state=IDLE, fifo_rd_en=0, cp_valid=0,
//   cp_offset=0, cp_len=0, cp_last=0, busy=0, err=0, byte_cnt=0.
//   States:
//   - IDLE: fifo_rd_en = !fifo_empty (combinational; never 1 while fifo_empty or srst).
//     If rd_en=1, go to FETCH.
//   - FETCH: capture fifo_dout into off_r/rem_r/last_r.
//     off==0 or len==0: token is discarded, err<=1, go to IDLE.
//     Otherwise go to ISSUE.
//   - ISSUE: cp_valid=1.
//     - cp_len = min(rem_r, CHUNK, off_r). Limiting by offset keeps overlapping
//       copies reading only bytes that are already written.
//     - cp_offset = off_r.
//     - cp_last = last_r && (rem_r == cp_len).
//     - On cp_valid && cp_ready: rem_r <= rem_r - cp_len. If the result is 0, go to IDLE;
//       else stay in ISSUE with the next chunk presented the following cycle.
//   Handshake:
//   - cp_* are registered and held stable while cp_valid && !cp_ready.
//   - cp_valid never drops without acceptance.
//   - Back-to-back chunks of one token: one chunk per cycle when cp_ready is held high.
//   Latency:
//   - fifo_rd_en at cycle t -> first cp_valid at t+2.
//   - Last chunk accepted at n -> next fifo_rd_en no earlier than n+1.
//   Arithmetic:
//   - min() is unsigned 16-bit; cp_len <= CHUNK <= 64.
//   - rem_r never underflows, because cp_len <= rem_r.
//   Boundaries:
//   - fifo_empty in IDLE: stay in IDLE, no pop.
//   - length=65535: handled by chunking, no overflow.
//   - off < CHUNK: chunks are off bytes each, plus a remainder.
//   - srst mid-token: the token is abandoned; the FIFO is reset in the same cycle by the system.
//   - cp_ready high while cp_valid low: ignored.
// CONFIGURATION
//   COPY_READER_STATS_EN defined:
//   - byte_cnt port exists.
//   - 32-bit count of bytes accepted by the engine (+cp_len on each cp_valid&&cp_ready).
//   - Wraps modulo 2^32; cleared by srst; discarded tokens are not counted.
//   COPY_READER_STATS_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//   1. {0,100,40}, ready=1 -> chunks (100,16),(100,16),(100,8).
//      cp_last=0; first cp_valid 2 cycles after rd_en.
//   2. {1,3,10} -> chunks (3,3),(3,3),(3,3),(3,1); cp_last=1 only on the 1-byte chunk.
//   3. {0,20,20}, ready low for 5 cycles -> cp_valid, cp_offset=20, cp_len=16 held stable.
//      After ready is released: (20,16),(20,4).
//   4. {0,0,8} then {0,5,0} then {0,8,8} -> first two dropped, err=1 sticky.
//      Only chunk (8,8) is issued; err stays 1.
//   5. fifo_empty=1 for 10 cycles -> fifo_rd_en=0 throughout.
//      srst during ISSUE of {0,50,64} -> next cycle cp_valid=0, busy=0, state IDLE.
//   6. COPY_READER_STATS_EN: tokens len 40, 10, 65535 accepted -> byte_cnt=65585.
//      srst -> 0.

Source files
------------

// File: rtl/copy_token_reader.sv
// Pops copy tokens {last, offset, length} from the parser FIFO and issues overlap-safe chunks to the copy engine.
// Optional byte counter: define COPY_READER_STATS_EN to add the byte_cnt port.
module copy_token_reader #(
    parameter int WIDTH = 33,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             cp_valid,
    input  logic             cp_ready,
    output logic [15:0]      cp_offset,
    output logic [15:0]      cp_len,
    output logic             cp_last,
    output logic             busy,
    output logic             err
`ifdef COPY_READER_STATS_EN
    ,
    output logic [31:0]      byte_cnt
`endif
);

    localparam logic [15:0] CHUNK_W = 16'(CHUNK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] off_q;
    logic [15:0] rem_q;
    logic        last_q;
    logic        cp_valid_q;
    logic [15:0] cp_offset_q;
    logic [15:0] cp_len_q;
    logic        cp_last_q;
    logic        err_q;

    logic        tok_last;
    logic [15:0] tok_off;
    logic [15:0] tok_len;
    logic [15:0] fetch_len;
    logic [15:0] rem_left;
    logic [15:0] next_len;
    logic        accept;

    // Chunk never exceeds the offset, so an overlapping copy only reads bytes already written.
    function automatic logic [15:0] chunk_len(input logic [15:0] rem, input logic [15:0] off);
        logic [15:0] m;
        m = (rem < CHUNK_W) ? rem : CHUNK_W;
        if (off < m) begin
            m = off;
        end
        return m;
    endfunction

    assign tok_last  = fifo_dout[32];
    assign tok_off   = fifo_dout[31:16];
    assign tok_len   = fifo_dout[15:0];
    assign fetch_len = chunk_len(tok_len, tok_off);
    assign accept    = cp_valid_q && cp_ready;
    assign rem_left  = rem_q - cp_len_q;
    assign next_len  = chunk_len(rem_left, off_q);

    assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !srst;
    assign cp_valid   = cp_valid_q;
    assign cp_offset  = cp_offset_q;
    assign cp_len     = cp_len_q;
    assign cp_last    = cp_last_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            off_q       <= 16'd0;
            rem_q       <= 16'd0;
            last_q      <= 1'b0;
            cp_valid_q  <= 1'b0;
            cp_offset_q <= 16'd0;
            cp_len_q    <= 16'd0;
            cp_last_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_rd_en) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    off_q  <= tok_off;
                    rem_q  <= tok_len;
                    last_q <= tok_last;
                    if (tok_off == 16'd0 || tok_len == 16'd0) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        // First chunk is built straight from the FIFO word to hit the two-cycle latency.
                        cp_valid_q  <= 1'b1;
                        cp_offset_q <= tok_off;
                        cp_len_q    <= fetch_len;
                        cp_last_q   <= tok_last && (tok_len == fetch_len);
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        rem_q <= rem_left;
                        if (rem_left == 16'd0) begin
                            cp_valid_q <= 1'b0;
                            cp_last_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            cp_len_q  <= next_len;
                            cp_last_q <= last_q && (rem_left == next_len);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef COPY_READER_STATS_EN
    logic [31:0] byte_cnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            byte_cnt_q <= 32'd0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + {16'd0, cp_len_q};
        end
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_copy_token_reader.sv
// Scoreboard bench for copy_token_reader: a queue-backed FIFO model feeds tokens, expected chunks are checked on acceptance.
module tb_copy_token_reader;

    localparam int CHUNK = 16;

    logic        clk = 1'b0;
    logic        srst;
    logic        fifo_empty;
    logic [32:0] fifo_dout = 33'd0;
    logic        fifo_rd_en;
    logic        cp_valid;
    logic        cp_ready;
    logic [15:0] cp_offset;
    logic [15:0] cp_len;
    logic        cp_last;
    logic        busy;
    logic        err;
`ifdef COPY_READER_STATS_EN
    logic [31:0] byte_cnt;
`endif

    always #5 clk = ~clk;

    copy_token_reader #(.WIDTH(33), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .cp_valid   (cp_valid),
        .cp_ready   (cp_ready),
        .cp_offset  (cp_offset),
        .cp_len     (cp_len),
        .cp_last    (cp_last),
        .busy       (busy),
        .err        (err)
`ifdef COPY_READER_STATS_EN
        ,
        .byte_cnt   (byte_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] off;
        logic [15:0] len;
        logic        last;
    } chunk_t;

    chunk_t      exp_q[$];
    logic [32:0] tok_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        rand_ready = 1'b0;

    // FIFO model: registered read, data valid the cycle after the pop.
    assign fifo_empty = (tok_q.size() == 0);
    always @(posedge clk) begin
        if (fifo_rd_en && tok_q.size() > 0) begin
            fifo_dout <= tok_q.pop_front();
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_token(input int off, input int len, input bit last);
        int     rem;
        int     c;
        chunk_t e;
        tok_q.push_back({last, 16'(off), 16'(len)});
        $display("token off=%0d len=%0d last=%0d", off, len, last);
        if (off != 0 && len != 0) begin
            rem = len;
            while (rem > 0) begin
                c = rem;
                if (c > CHUNK) c = CHUNK;
                if (c > off) c = off;
                e.off  = 16'(off);
                e.len  = 16'(c);
                e.last = last && (rem == c);
                exp_q.push_back(e);
                rem -= c;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            tick();
            if (rand_ready) cp_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && tok_q.size() == 0 && !busy) break;
        end
        check_eq("drain_in_budget", 64'(k < budget), 64'd1);
    endtask

    // Monitor: compare on acceptance, check first-chunk latency and stall stability.
    int     cyc = 0;
    int     rd_cyc = -100;
    logic   prev_v = 1'b0;
    logic   prev_r = 1'b0;
    logic   prev_srst = 1'b1;
    chunk_t prev_c = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chunk_t e;
        if (!srst) begin
            if (fifo_rd_en) rd_cyc = cyc;
            if (cp_valid && !prev_v && !prev_srst)
                check_eq("first_valid_latency", 64'(cyc - rd_cyc), 64'd2);
            if (prev_v && !prev_r && !prev_srst) begin
                check_eq("stall_valid_held", 64'(cp_valid), 64'd1);
                check_eq("stall_chunk_held", 64'({cp_offset, cp_len, cp_last}), 64'(prev_c));
            end
            if (cp_valid && cp_ready) begin
                check_eq("chunk_was_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("chunk", 64'({cp_offset, cp_len, cp_last}), 64'(e));
                end
            end
        end
        prev_v    = cp_valid;
        prev_r    = cp_ready;
        prev_srst = srst;
        prev_c    = {cp_offset, cp_len, cp_last};
    end

    initial begin
        int k;
        srst     = 1'b1;
        cp_ready = 1'b0;
        push_token(100, 40, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_rd_en_held_low", 64'(fifo_rd_en), 64'd0);
        check_eq("rst_cp_valid", 64'(cp_valid), 64'd0);
        check_eq("rst_cp_offset", 64'(cp_offset), 64'd0);
        check_eq("rst_cp_len", 64'(cp_len), 64'd0);
        check_eq("rst_cp_last", 64'(cp_last), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);

        // Plain chunking and overlap-limited chunking
        tick();
        srst     = 1'b0;
        cp_ready = 1'b1;
        wait_idle(200);
        push_token(3, 10, 1'b1);
        wait_idle(200);

        // Engine stalls for several cycles on the first chunk
        cp_ready = 1'b0;
        push_token(20, 20, 1'b0);
        repeat (7) tick();
        @(negedge clk);
        check_eq("stall_valid", 64'(cp_valid), 64'd1);
        check_eq("stall_offset", 64'(cp_offset), 64'd20);
        check_eq("stall_len", 64'(cp_len), 64'd16);
        tick();
        cp_ready = 1'b1;
        wait_idle(200);
        check_eq("err_clean", 64'(err), 64'd0);

        // Illegal tokens are dropped and set the sticky error
        push_token(0, 8, 1'b0);
        push_token(5, 0, 1'b0);
        push_token(8, 8, 1'b0);
        wait_idle(200);
        @(negedge clk);
        check_eq("err_set", 64'(err), 64'd1);

        // Maximum length plus random tokens under random back-pressure
        tick();
        push_token(1000, 65535, 1'b0);
        wait_idle(6000);
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            push_token(int'($urandom_range(1, 40)), int'($urandom_range(1, 100)), 1'($urandom_range(0, 1)));
        wait_idle(5000);
        rand_ready = 1'b0;
        cp_ready   = 1'b1;
        @(negedge clk);
        check_eq("err_sticky", 64'(err), 64'd1);

        // Empty FIFO: no pops
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("no_pop_when_empty", 64'(fifo_rd_en), 64'd0);
        end

        // Reset in the middle of a token abandons it
        tick();
        cp_ready = 1'b0;
        push_token(50, 64, 1'b0);
        for (k = 0; k < 20 && !cp_valid; k++) tick();
        check_eq("mid_token_valid_seen", 64'(cp_valid), 64'd1);
        srst = 1'b1;
        tick();
        exp_q.delete();
        @(negedge clk);
        check_eq("srst_mid_valid", 64'(cp_valid), 64'd0);
        check_eq("srst_mid_busy", 64'(busy), 64'd0);
        check_eq("srst_mid_err", 64'(err), 64'd0);
        tick();
        srst     = 1'b0;
        cp_ready = 1'b1;
        push_token(8, 8, 1'b1);
        wait_idle(200);

`ifdef COPY_READER_STATS_EN
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check_eq("byte_cnt_rst", 64'(byte_cnt), 64'd0);
        tick();
        push_token(100, 40, 1'b0);
        push_token(10, 10, 1'b0);
        push_token(0, 9, 1'b0);
        push_token(64, 65535, 1'b1);
        wait_idle(10000);
        @(negedge clk);
        check_eq("byte_cnt_total", 64'(byte_cnt), 64'd65585);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check_eq("byte_cnt_cleared", 64'(byte_cnt), 64'd0);
`endif

        repeat (3) tick();
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
